mem_bridge: RTL and testbench

Memory-side stage directly downstream of the core: accepts the core's single-word read/write requests (addr, mem_ren, mem_wen, write data), services them from an internal word-addressed RAM after a programmable number of wait states, and returns read data with a one-cycle ready pulse. It also flags misaligned, out-of-range and conflicting requests so the core's fetch/execute sequencing can stall or trap instead of consuming garbage.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_array.sv | 41 ++++
 rtl/mem_bridge.sv | 149 ++++++++++++++
 tb/tb_mem_bridge.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the core memory interface and the memory bridge.
package mem_pkg;

  // Core memory-interface widths
  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_BE_W   = 4;
  localparam int unsigned MEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_RESP = 2'b10
  } mem_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_e;

  // A request is rejected when it is ambiguous, misaligned or past the end of the RAM
  function automatic logic req_reject(input logic [MEM_ADDR_W-1:0] addr,
                                      input logic ren, input logic wen,
                                      input int unsigned words);
    logic [31:0] word;
    word = {2'b00, addr[31:2]};
    return (ren && wen) || (addr[1:0] != 2'b00) || (word >= words);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed single-port RAM with byte-lane writes and a registered read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr,
  input  logic                  clr,
  input  logic [MEM_BE_W-1:0]   be,
  input  logic [AW-1:0]         idx,
  input  logic [MEM_DATA_W-1:0] wdata,
  output logic [MEM_DATA_W-1:0] q
);

  logic [MEM_DATA_W-1:0] mem [WORDS];

  // Byte-lane write; storage is never reset
  always_ff @(posedge clk) begin
    if (en && wr) begin
      for (int i = 0; i < MEM_BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register: holds until the next completion, zero on writes and rejects
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= wr ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// Core-facing memory bridge: request checking, wait-state sequencing and RAM access.
module mem_bridge
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [MEM_CNT_W-1:0] WAIT_LD = MEM_CNT_W'(WAIT_CYCLES);

  mem_state_e           state;
  logic [MEM_CNT_W-1:0] cnt;
  logic [AW-1:0]        req_idx;
  logic [3:0]           req_be;
  logic [31:0]          req_wdata;
  mem_op_e              req_op;

  logic          req_c;
  logic          reject_c;
  logic          acc_en;
  logic          acc_wr;
  logic          acc_clr;
  logic [3:0]    acc_be;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;

  assign req_c    = mem_ren | mem_wen;
  assign reject_c = req_reject(addr, mem_ren, mem_wen, MEM_WORDS);

  // RAM access strobe: live request with zero wait states, or last wait cycle
  always_comb begin
    acc_en    = 1'b0;
    acc_wr    = 1'b0;
    acc_clr   = 1'b0;
    acc_be    = req_be;
    acc_idx   = req_idx;
    acc_wdata = req_wdata;
    if (!rst) begin
      case (state)
        MEM_IDLE: begin
          if (req_c) begin
            if (reject_c) begin
              acc_clr = 1'b1;
            end else if (WAIT_LD == '0) begin
              acc_en    = 1'b1;
              acc_wr    = mem_wen;
              acc_be    = be;
              acc_idx   = addr[AW+1:2];
              acc_wdata = wdata;
            end
          end
        end
        MEM_WAIT: begin
          if (cnt <= MEM_CNT_W'(1)) begin
            acc_en = 1'b1;
            acc_wr = (req_op == OP_WR);
          end
        end
        default: ;
      endcase
    end
  end

  // Request FSM with wait counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MEM_IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      req_idx   <= '0;
      req_be    <= '0;
      req_wdata <= '0;
      req_op    <= OP_RD;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (req_c) begin
            req_idx   <= addr[AW+1:2];
            req_be    <= be;
            req_wdata <= wdata;
            req_op    <= mem_wen ? OP_WR : OP_RD;
            busy      <= 1'b1;
            if (reject_c) begin
              state <= MEM_RESP;
              ready <= 1'b1;
              err   <= 1'b1;
            end else if (WAIT_LD == '0) begin
              state <= MEM_RESP;
              ready <= 1'b1;
            end else begin
              state <= MEM_WAIT;
              cnt   <= WAIT_LD;
            end
          end
        end
        MEM_WAIT: begin
          if (cnt <= MEM_CNT_W'(1)) begin
            cnt   <= '0;
            state <= MEM_RESP;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - MEM_CNT_W'(1);
          end
        end
        MEM_RESP: begin
          state <= MEM_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= MEM_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .WORDS(MEM_WORDS),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .en   (acc_en),
    .wr   (acc_wr),
    .clr  (acc_clr),
    .be   (acc_be),
    .idx  (acc_idx),
    .wdata(acc_wdata),
    .q    (rdata)
  );

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge with three wait-state configurations (2, 3, 0).
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ren_s   [3];
  logic        wen_s   [3];
  logic [31:0] rdata_s [3];
  logic        ready_s [3];
  logic        err_s   [3];
  logic        busy_s  [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bridge #(.MEM_WORDS(1024), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .addr(addr), .mem_ren(ren_s[0]), .mem_wen(wen_s[0]),
    .be(be), .wdata(wdata), .rdata(rdata_s[0]), .ready(ready_s[0]),
    .err(err_s[0]), .busy(busy_s[0]));

  mem_bridge #(.MEM_WORDS(1024), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst), .addr(addr), .mem_ren(ren_s[1]), .mem_wen(wen_s[1]),
    .be(be), .wdata(wdata), .rdata(rdata_s[1]), .ready(ready_s[1]),
    .err(err_s[1]), .busy(busy_s[1]));

  mem_bridge #(.MEM_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .addr(addr), .mem_ren(ren_s[2]), .mem_wen(wen_s[2]),
    .be(be), .wdata(wdata), .rdata(rdata_s[2]), .ready(ready_s[2]),
    .err(err_s[2]), .busy(busy_s[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request in cycle 0 and wait (bounded) for its ready pulse
  task automatic req(input int sel, input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic e);
    @(posedge clk); #1;
    addr = a; be = b; wdata = d; ren_s[sel] = r; wen_s[sel] = w;
    @(posedge clk); #1;
    ren_s[sel] = 1'b0; wen_s[sel] = 1'b0;
    lat = -1; rd = 32'hxxxx_xxxx; e = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      if (ready_s[sel]) begin
        lat = c; rd = rdata_s[sel]; e = err_s[sel];
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        e;
  logic [6:0]  rpat;
  logic [6:0]  bpat;
  logic        seen;

  initial begin
    rst = 1'b1; addr = '0; be = '0; wdata = '0;
    for (int i = 0; i < 3; i++) begin ren_s[i] = 1'b0; wen_s[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_rdata", rdata_s[0], 32'h0);
    chk("rst_flags", {29'h0, ready_s[0], err_s[0], busy_s[0]}, 32'h0);

    // Full write / read with two wait states
    req(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, rd, e);
    chk("wr10_lat", 32'(lat), 32'd3);
    chk("wr10_err", {31'h0, e}, 32'h0);
    chk("wr10_rdata", rd, 32'h0);
    req(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, e);
    chk("rd10_lat", 32'(lat), 32'd3);
    chk("rd10_rdata", rd, 32'hDEADBEEF);

    // Partial byte-lane write
    req(0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h11223344, lat, rd, e);
    req(0, 1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, lat, rd, e);
    chk("pw_lat", 32'(lat), 32'd3);
    req(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, lat, rd, e);
    chk("pw_rdata", rd, 32'h11BB33DD);

    // Rejections: rdata is nonzero beforehand so the clear is visible
    req(0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h01234567, lat, rd, e);
    req(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, e);
    req(0, 1'b1, 1'b0, 32'h12, 4'h0, 32'h0, lat, rd, e);
    chk("mis_resp", {rd[29:0], e, 1'b0} | 32'(lat), 32'h3);
    chk("mis_rdata", rd, 32'h0);
    req(0, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, lat, rd, e);
    chk("oor_lat", 32'(lat), 32'd1);
    chk("oor_err", {31'h0, e}, 32'h1);
    req(0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hFFFFFFFF, lat, rd, e);
    chk("both_lat", 32'(lat), 32'd1);
    chk("both_err", {31'h0, e}, 32'h1);
    chk("both_rdata", rd, 32'h0);
    req(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, lat, rd, e);
    chk("rej_ram0", rd, 32'h01234567);
    chk("rej_ram0_err", {31'h0, e}, 32'h0);

    // Requests held high through WAIT/RESP are dropped, next accepted after ready
    @(posedge clk); #1;
    addr = 32'h10; ren_s[0] = 1'b1;
    rpat = '0; bpat = '0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 5) ren_s[0] = 1'b0;
      rpat[c-1] = ready_s[0];
      bpat[c-1] = busy_s[0];
      if (c == 7) chk("drop_rdata", rdata_s[0], 32'hDEADBEEF);
    end
    chk("drop_ready", {25'h0, rpat}, 32'h44);
    chk("drop_busy", {25'h0, bpat}, 32'h77);

    // Reset aborts a pending write
    req(1, 1'b0, 1'b1, 32'h30, 4'hF, 32'h13579BDF, lat, rd, e);
    chk("w3_lat", 32'(lat), 32'd4);
    req(1, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0, lat, rd, e);
    chk("w3_rd30", rd, 32'h13579BDF);
    @(posedge clk); #1;
    addr = 32'h30; be = 4'hF; wdata = 32'hCAFEF00D; wen_s[1] = 1'b1;
    @(posedge clk); #1;
    wen_s[1] = 1'b0;
    chk("abort_busy", {31'h0, busy_s[1]}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_rdata", rdata_s[1], 32'h0);
    chk("abort_flags", {29'h0, ready_s[1], err_s[1], busy_s[1]}, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen = seen | ready_s[1];
    end
    chk("abort_noready", {31'h0, seen}, 32'h0);
    req(1, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0, lat, rd, e);
    chk("abort_rd30", rd, 32'h13579BDF);

    // Zero wait states, alternating write/read
    req(2, 1'b0, 1'b1, 32'h40, 4'hF, 32'h5, lat, rd, e);
    chk("w0_wr_lat", 32'(lat), 32'd1);
    req(2, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, lat, rd, e);
    chk("w0_rd_lat", 32'(lat), 32'd1);
    chk("w0_rd_data", rd, 32'h00000005);
    req(2, 1'b0, 1'b1, 32'h40, 4'hF, 32'hA, lat, rd, e);
    chk("w0_wr2_rdata", rd, 32'h0);
    req(2, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, lat, rd, e);
    chk("w0_rd2_data", rd, 32'h0000000A);

    // be=0 write is a legal no-op
    req(2, 1'b0, 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, lat, rd, e);
    chk("be0_err", {31'h0, e}, 32'h0);
    req(2, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, lat, rd, e);
    chk("be0_data", rd, 32'h0000000A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
